// File: rtl/router_pkg.sv
// router_pkg: shared state type and default sizes for the router datapath
// (router_controller, router_mem_arbiter and the packet memory agree on these).
package router_pkg;

  localparam int DEF_AURORA_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH        = 10;
  localparam int DEF_NUMBER_PACKET     = 19;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } arb_state_t;

  // Encoding of the last granted side for round-robin arbitration.
  localparam logic RR_READ  = 1'b0;
  localparam logic RR_WRITE = 1'b1;

endpackage

// File: rtl/router_burst_agen.sv
// router_burst_agen: loadable wrapping address counter plus beat counter.
// load captures the base and clears the beat count; step advances both.
// last flags the final beat of a NUMBER_PACKET-beat burst.
module router_burst_agen
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int NUMBER_PACKET = DEF_NUMBER_PACKET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int BEAT_W = $clog2(NUMBER_PACKET + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUMBER_PACKET - 1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  // Next counter values: load has priority over step; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (load) begin
      addr_d = base;
      beat_d = '0;
    end else if (step) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

  assign addr = addr_q;
  assign last = (beat_q == LAST_BEAT);

endmodule

// File: rtl/router_mem_arbiter.sv
// router_mem_arbiter: shares the single-port packet memory between the read
// requester and the write requester, running fixed NUMBER_PACKET-beat bursts.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests); when undefined, read has fixed priority.
//
// Handshake: a read beat happens in RD_BURST whenever rd_ready is high; the
// data appears on rd_data with rd_valid one cycle later. A write beat happens
// in WR_BURST whenever wr_valid is high (wr_ready is high for the whole burst).
// Requests are level signals sampled only in IDLE; grants are 1-cycle pulses.
module router_mem_arbiter
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = DEF_AURORA_DATA_WIDTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int NUMBER_PACKET     = DEF_NUMBER_PACKET
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_req,
  input  logic [ADDR_WIDTH-1:0]        arbiter_src_addr,
  output logic                         read_gnt,
  input  logic                         write_req,
  input  logic [ADDR_WIDTH-1:0]        arbiter_dst_addr,
  output logic                         write_gnt,
  input  logic                         rd_ready,
  output logic [AURORA_DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         rd_done,
  input  logic [AURORA_DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         wr_done,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [AURORA_DATA_WIDTH-1:0] mem_wdata,
  input  logic [AURORA_DATA_WIDTH-1:0] mem_rdata,
  output arb_state_t                   dbg_state_o
);

  arb_state_t            state_q, state_d;
  logic                  grant_rd, grant_wr;
  logic                  rd_beat, wr_beat;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_beat;
  logic read_gnt_q, write_gnt_q, rd_valid_q, rd_done_q, wr_ready_q, wr_done_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;
`endif

  // Arbitration in IDLE, beat qualification in the burst states, next state.
  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    rd_beat  = 1'b0;
    wr_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_req && write_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (rr_last_q == RR_WRITE) grant_rd = 1'b1;
          else                       grant_wr = 1'b1;
`else
          grant_rd = 1'b1;
`endif
        end else begin
          grant_rd = read_req;
          grant_wr = write_req;
        end
        if (grant_rd)      state_d = RD_BURST;
        else if (grant_wr) state_d = WR_BURST;
      end
      RD_BURST: begin
        rd_beat = rd_ready;
        if (rd_ready && last_beat) state_d = IDLE;
      end
      WR_BURST: begin
        wr_beat = wr_valid;
        if (wr_valid && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which side won most recently.
  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_rd)      rr_last_d = RR_READ;
    else if (grant_wr) rr_last_d = RR_WRITE;
  end

  // Round-robin history; resets to write so read wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= RR_WRITE;
    else     rr_last_q <= rr_last_d;
  end
`endif

  router_burst_agen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUMBER_PACKET (NUMBER_PACKET)
  ) u_agen (
    .clk  (clk),
    .rst  (rst),
    .load (grant_rd | grant_wr),
    .base (grant_rd ? arbiter_src_addr : arbiter_dst_addr),
    .step (rd_beat | wr_beat),
    .addr (cur_addr),
    .last (last_beat)
  );

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_gnt_q  <= 1'b0;
      write_gnt_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_gnt_q  <= grant_rd;
      write_gnt_q <= grant_wr;
      rd_valid_q  <= rd_beat;
      rd_done_q   <= rd_beat & last_beat;
      wr_ready_q  <= (state_d == WR_BURST);
      wr_done_q   <= wr_beat & last_beat;
    end
  end

  // Memory strobes are combinational so a beat reaches memory in its own cycle;
  // address and data are zeroed when no access is made.
  assign mem_en    = rd_beat | wr_beat;
  assign mem_we    = wr_beat;
  assign mem_addr  = (rd_beat | wr_beat) ? cur_addr : '0;
  assign mem_wdata = wr_beat ? wr_data : '0;

  assign read_gnt    = read_gnt_q;
  assign write_gnt   = write_gnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_done     = rd_done_q;
  assign rd_data     = rd_valid_q ? mem_rdata : '0;
  assign wr_ready    = wr_ready_q;
  assign wr_done     = wr_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_mem_arbiter.sv
// tb_router_mem_arbiter: table-driven vectors for single bursts (read wrap,
// gapped write, throttled read-back, mid-burst reset) plus hand-written
// sequences for arbitration and a request pulse during a write burst.
module tb_router_mem_arbiter;
  import router_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NP = 19;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          read_req, write_req, rd_ready, wr_valid;
  logic [AW-1:0] arbiter_src_addr, arbiter_dst_addr;
  logic [DW-1:0] wr_data;
  logic          read_gnt, write_gnt, rd_valid, rd_done, wr_ready, wr_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd_data;
  logic [DW-1:0] mem_rdata;
  arb_state_t    dbg_state;

  router_mem_arbiter #(
    .AURORA_DATA_WIDTH (DW),
    .ADDR_WIDTH        (AW),
    .NUMBER_PACKET     (NP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .read_req         (read_req),
    .arbiter_src_addr (arbiter_src_addr),
    .read_gnt         (read_gnt),
    .write_req        (write_req),
    .arbiter_dst_addr (arbiter_dst_addr),
    .write_gnt        (write_gnt),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_done          (rd_done),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_done          (wr_done),
    .mem_en           (mem_en),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- packet memory model (1-cycle read latency) ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_word(input int i);
    return {16'h5A5A, 16'(i), 16'hF00D, 16'(i ^ 16'hFFFF)};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // ---------------- scoreboard counters / compare ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, rreq, rrdy, wreq, wval;
    logic [AW-1:0] src, dst;
    logic [DW-1:0] wdata;
    logic [1:0]    e_state;
    logic          e_rgnt, e_wgnt, e_en, e_we, e_rval, e_rdone, e_wrdy, e_wdone;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat, e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{default: '0};
    v.e_state = IDLE;
    return v;
  endfunction

  // Read burst from base; optional rd_ready toggling; optional reset at a beat.
  function automatic void build_read(input logic [AW-1:0] base, input bit toggle, input int rst_beat);
    vec_t v;
    int beats, k;
    bit prev_beat, prev_last, beat;
    logic [AW-1:0] prev_addr, a;
    v = idle_vec(); v.rreq = 1'b1; v.src = base; v.rrdy = 1'b1;
    tbl.push_back(v);
    beats = 0; k = 1; prev_beat = 0; prev_last = 0; prev_addr = '0;
    while (beats < NP || prev_beat) begin
      v = idle_vec();
      v.rrdy    = toggle ? ((k - 1) % 2 == 0) : 1'b1;
      v.e_rgnt  = (k == 1);
      v.e_state = (beats < NP) ? RD_BURST : IDLE;
      beat      = (beats < NP) && v.rrdy;
      a         = base + AW'(beats);
      if (beat) begin v.e_en = 1'b1; v.e_addr = a; end
      v.e_rval  = prev_beat;
      v.e_rdone = prev_beat && prev_last;
      v.e_rdata = prev_beat ? exp_mem[prev_addr] : '0;
      if (rst_beat >= 0 && beats == rst_beat && beat) begin
        v.rst = 1'b1;
        tbl.push_back(v);
        v = idle_vec(); v.rrdy = 1'b1;
        tbl.push_back(v);
        return;
      end
      tbl.push_back(v);
      prev_last = beat && (beats == NP - 1);
      prev_beat = beat;
      prev_addr = a;
      if (beat) beats++;
      k++;
    end
  endfunction

  // Write burst to base with wr_valid low for 3 cycles after the 5th beat.
  function automatic void build_write(input logic [AW-1:0] base);
    vec_t v;
    int beats, gaps, k;
    bit prev_last, beat;
    logic [AW-1:0] a;
    v = idle_vec(); v.wreq = 1'b1; v.dst = base;
    tbl.push_back(v);
    beats = 0; gaps = 0; k = 1; prev_last = 0;
    while (beats < NP || prev_last) begin
      v = idle_vec();
      v.wdata   = 64'hDEAD_BEEF_0000_0000 | 64'(k * 7);
      v.e_wgnt  = (k == 1);
      v.e_state = (beats < NP) ? WR_BURST : IDLE;
      v.e_wrdy  = (beats < NP);
      v.wval    = !(beats == 5 && gaps < 3);
      if (beats == 5 && gaps < 3) gaps++;
      beat      = (beats < NP) && v.wval;
      v.e_wdone = prev_last;
      if (beat) begin
        a = base + AW'(beats);
        v.e_en = 1'b1; v.e_we = 1'b1; v.e_addr = a; v.e_wdat = v.wdata;
        exp_mem[a] = v.wdata;
      end
      tbl.push_back(v);
      prev_last = beat && (beats == NP - 1);
      if (beat) beats++;
      k++;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    rst = v.rst; read_req = v.rreq; arbiter_src_addr = v.src; rd_ready = v.rrdy;
    write_req = v.wreq; arbiter_dst_addr = v.dst; wr_valid = v.wval; wr_data = v.wdata;
    @(negedge clk);
    s = $sformatf("v%0d", idx);
    chk({s, ".state"},     64'(dbg_state), 64'(v.e_state));
    chk({s, ".read_gnt"},  64'(read_gnt),  64'(v.e_rgnt));
    chk({s, ".write_gnt"}, 64'(write_gnt), 64'(v.e_wgnt));
    chk({s, ".mem_en"},    64'(mem_en),    64'(v.e_en));
    chk({s, ".mem_we"},    64'(mem_we),    64'(v.e_we));
    chk({s, ".mem_addr"},  64'(mem_addr),  64'(v.e_addr));
    chk({s, ".mem_wdata"}, mem_wdata,      v.e_wdat);
    chk({s, ".rd_valid"},  64'(rd_valid),  64'(v.e_rval));
    chk({s, ".rd_data"},   rd_data,        v.e_rdata);
    chk({s, ".rd_done"},   64'(rd_done),   64'(v.e_rdone));
    chk({s, ".wr_ready"},  64'(wr_ready),  64'(v.e_wrdy));
    chk({s, ".wr_done"},   64'(wr_done),   64'(v.e_wdone));
    tick();
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t v;
    int ng, cyc, rgnt_cnt, we_cnt, wdone_cnt;
    int gcyc [3];
    logic gside [3];
    logic exp_side [3];

    rst = 1'b1; read_req = 1'b0; write_req = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
    arbiter_src_addr = '0; arbiter_dst_addr = '0; wr_data = '0; mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_word(i);
      exp_mem[i] = init_word(i);
    end
    repeat (2) @(posedge clk);
    #1;

    v = idle_vec(); v.rst = 1'b1;
    tbl.push_back(v);
    tbl.push_back(idle_vec());
    build_read(10'h3F0, 1'b0, -1);     // wraps 0x3FF -> 0x000
    tbl.push_back(idle_vec());
    build_write(10'h010);              // 3-cycle wr_valid gap
    tbl.push_back(idle_vec());
    build_read(10'h010, 1'b1, -1);     // read back, rd_ready every other cycle
    tbl.push_back(idle_vec());
    build_read(10'h100, 1'b0, 10);     // reset at beat 10
    build_read(10'h155, 1'b0, -1);     // fresh burst after reset
    tbl.push_back(idle_vec());

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // ---- arbitration: both requests held, three grants observed ----
    rst = 1'b1; tick(); rst = 1'b0;
    read_req = 1'b1; write_req = 1'b1;
    arbiter_src_addr = 10'h100; arbiter_dst_addr = 10'h200;
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 64'h1234;
    ng = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin gcyc[i] = 0; gside[i] = 1'b0; end
    while (ng < 3 && cyc < 200) begin
      @(negedge clk);
      if (read_gnt || write_gnt) begin
        gside[ng] = write_gnt;
        gcyc[ng]  = cyc;
        ng++;
      end
      cyc++;
      tick();
    end
    read_req = 1'b0; write_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_side[0] = 1'b0; exp_side[1] = 1'b1; exp_side[2] = 1'b0;
`else
    exp_side[0] = 1'b0; exp_side[1] = 1'b0; exp_side[2] = 1'b0;
`endif
    chk("arb.grant_count", 64'(ng), 64'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("arb.side%0d", i), 64'(gside[i]), 64'(exp_side[i]));
    chk("arb.turnaround01", 64'(gcyc[1] - gcyc[0]), 64'(NP + 1));
    chk("arb.turnaround12", 64'(gcyc[2] - gcyc[1]), 64'(NP + 1));
    cyc = 0;
    while (dbg_state != IDLE && cyc < 60) begin tick(); cyc++; end
    repeat (2) tick();
    chk("arb.drain_idle", 64'(dbg_state), 64'(IDLE));

    // ---- read_req pulse during a write burst is lost ----
    write_req = 1'b1; arbiter_dst_addr = 10'h300; wr_valid = 1'b1; rd_ready = 1'b1;
    tick();
    write_req = 1'b0;
    rgnt_cnt = 0; we_cnt = 0; wdone_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      read_req = (i == 5);
      @(negedge clk);
      if (read_gnt) rgnt_cnt++;
      if (wr_done)  wdone_cnt++;
      if (mem_en && mem_we) begin
        chk($sformatf("pulse.addr%0d", we_cnt), 64'(mem_addr), 64'(10'h300 + AW'(we_cnt)));
        we_cnt++;
      end
      tick();
    end
    read_req = 1'b0;
    chk("pulse.read_gnt_count", 64'(rgnt_cnt), 64'd0);
    chk("pulse.write_beats",    64'(we_cnt),   64'(NP));
    chk("pulse.wr_done_count",  64'(wdone_cnt), 64'd1);
    chk("pulse.final_state",    64'(dbg_state), 64'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
